// File: rtl/count_stage_pkg.sv
// Shared definitions for the count sampling stage: default sample width,
// FIFO entry layout and the counter terminal value.
package count_stage_pkg;

    localparam int CS_DATA_W = 8;
    localparam int CS_DEPTH  = 4;

    localparam logic [CS_DATA_W-1:0] COUNT_MAX = '1;

    // One buffered sample: wrap tag above the count value
    typedef struct packed {
        logic                 wrap;
        logic [CS_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Storage array for the sample FIFO: one synchronous write port and one
// asynchronous read port. The array itself carries no reset; validity is
// tracked by the pointers and level in the parent.
module sample_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Head entry is read combinationally for first-word-fall-through
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/count_sample_fifo.sv
// count_sample_fifo: samples a free-running event counter, tags MAX->0
// wrap-around and buffers samples in a small FWFT FIFO with a valid/ready
// output. The counter cannot be stalled, so samples arriving while the FIFO
// is full are dropped and the sticky overflow flag is raised.
// Optional feature macro: SAMPLE_DROP_CNT_EN adds a saturating 8-bit drop_cnt.
module count_sample_fifo
    import count_stage_pkg::*;
#(
    parameter int DATA_W = CS_DATA_W,
    parameter int DEPTH  = CS_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_wrap,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
`ifdef SAMPLE_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic                       overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic              wrap;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] prev;
    logic              prev_vld;
    logic              pop;
    logic              push;
    logic              drop;
    logic              wrap;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;

    // Handshake decode: a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        out_valid = (level != '0);
        pop       = out_valid & out_ready;
        push      = in_valid & ((level != FULL_LVL) | pop);
        drop      = in_valid & (level == FULL_LVL) & ~pop;
        wrap      = prev_vld & (prev == '1) & (in_data == '0);
        wr_entry  = '{wrap: wrap, data: in_data};
    end

    sample_fifo_mem #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Head fields are masked to zero while the FIFO is empty
    always_comb begin
        out_data = out_valid ? head.data : '0;
        out_wrap = out_valid & head.wrap;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Previous-sample tracking follows every valid sample, dropped or not
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (in_valid) begin
            prev     <= in_data;
            prev_vld <= 1'b1;
        end
    end

    // Sticky overflow flag; a drop outranks a coincident clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef SAMPLE_DROP_CNT_EN
    // Saturating drop counter; a clear coincident with a drop restarts at one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && clr_ovf) begin
            drop_cnt <= 8'd1;
        end else if (drop) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end else if (clr_ovf) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_count_sample_fifo.sv
// Testbench for count_sample_fifo: directed sample streams with hand-written
// expected FIFO contents queued at stimulus time and checked by a negedge
// monitor on every accepted pop, plus direct status checks.
// Honours SAMPLE_DROP_CNT_EN for the optional drop_cnt output.
module tb_count_sample_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr_ovf;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_wrap;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;
`ifdef SAMPLE_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [8:0]  exp_q[$];

    count_sample_fifo #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .out_ready (out_ready),
        .level     (level),
`ifdef SAMPLE_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic chk_dc(input string name, input int expected);
`ifdef SAMPLE_DROP_CNT_EN
        chk(name, int'(drop_cnt), expected);
`else
        if (expected < 0) $display("unreachable");
`endif
    endtask

    // One clock of stimulus; returns 1 time unit after the edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic w, input logic [7:0] d);
        exp_q.push_back({w, d});
    endtask

    // Scoreboard monitor: every accepted pop must match the queue head
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got data %0d wrap %0d, required no pop", out_data, out_wrap);
            end else begin
                automatic logic [8:0] e = exp_q.pop_front();
                chk("pop_data", int'(out_data), int'(e[7:0]));
                chk("pop_wrap", int'(out_wrap), int'(e[8]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; clr_ovf = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_wrap", int'(out_wrap), 0);
        chk_dc("rst_dcnt", 0);
        #5 reset = 1'b0;
        @(posedge clk); #1;

        // Reset mid-stream: fill, drop a 255, pop one, then reset with level 3
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(100 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'd255, 1'b0, 1'b0);
        chk("t1_level_full", int'(level), 4);
        chk("t1_ovf", int'(overflow), 1);
        chk("t1_head", int'(out_data), 100);
        expect_entry(1'b0, 8'd100);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("t1_level3", int'(level), 3);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t1_async_valid", int'(out_valid), 0);
        chk("t1_async_level", int'(level), 0);
        chk("t1_async_ovf", int'(overflow), 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        expect_entry(1'b0, 8'd0);
        cyc(1'b1, 8'd0, 1'b0, 1'b0);
        chk("t1_first_valid", int'(out_valid), 1);
        chk("t1_first_wrap", int'(out_wrap), 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

        // Wrap stream with consumer always ready
        expect_entry(1'b0, 8'd253);
        expect_entry(1'b0, 8'd254);
        expect_entry(1'b0, 8'd255);
        expect_entry(1'b1, 8'd0);
        expect_entry(1'b0, 8'd1);
        chk("t2_empty_before", int'(out_valid), 0);
        cyc(1'b1, 8'd253, 1'b1, 1'b0);
        chk("t2_latency_valid", int'(out_valid), 1);
        chk("t2_latency_data", int'(out_data), 253);
        cyc(1'b1, 8'd254, 1'b1, 1'b0);
        cyc(1'b1, 8'd255, 1'b1, 1'b0);
        cyc(1'b1, 8'd0,   1'b1, 1'b0);
        cyc(1'b1, 8'd1,   1'b1, 1'b0);
        chk("t2_stream_level", int'(level), 1);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("t2_drained", int'(level), 0);

        // Back-pressure: push 10..15 with consumer stalled
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(10 + i), 1'b0, 1'b0);
        chk("t3_full_noovf", int'(overflow), 0);
        for (int i = 4; i < 6; i++) cyc(1'b1, 8'(10 + i), 1'b0, 1'b0);
        chk("t3_level", int'(level), 4);
        chk("t3_head_held", int'(out_data), 10);
        chk("t3_ovf", int'(overflow), 1);
        chk_dc("t3_dcnt", 2);

        // Full with simultaneous pop and push
        expect_entry(1'b0, 8'd10);
        cyc(1'b1, 8'd16, 1'b1, 1'b0);
        chk("t4_level", int'(level), 4);
        chk_dc("t4_dcnt", 2);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("t4_clr_ovf", int'(overflow), 0);
        chk_dc("t4_clr_dcnt", 0);
        expect_entry(1'b0, 8'd11);
        cyc(1'b1, 8'd17, 1'b1, 1'b0);
        chk("t4_level2", int'(level), 4);
        chk("t4_no_ovf", int'(overflow), 0);

        // Dropped 255 still arms the wrap tag for the accepted 0
        cyc(1'b1, 8'd255, 1'b0, 1'b0);
        chk("t5_drop_ovf", int'(overflow), 1);
        expect_entry(1'b0, 8'd12);
        cyc(1'b1, 8'd0, 1'b1, 1'b0);
        chk("t5_level", int'(level), 4);

        // Clear versus drop priority
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("t6_pre_clr", int'(overflow), 0);
        cyc(1'b1, 8'd50, 1'b0, 1'b1);
        chk("t6_set_wins", int'(overflow), 1);
        chk_dc("t6_dcnt_one", 1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("t6_clr_alone", int'(overflow), 0);
        chk_dc("t6_dcnt_zero", 0);
        expect_entry(1'b0, 8'd13);
        expect_entry(1'b0, 8'd16);
        expect_entry(1'b0, 8'd17);
        expect_entry(1'b1, 8'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("t6_empty_valid", int'(out_valid), 0);
        chk("t6_empty_data", int'(out_data), 0);
        chk("t6_empty_wrap", int'(out_wrap), 0);
        chk("t6_empty_level", int'(level), 0);

        // Counter gap into zero is not a wrap (previous sample was 50)
        expect_entry(1'b0, 8'd0);
        cyc(1'b1, 8'd0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

`ifdef SAMPLE_DROP_CNT_EN
        // Drop counter saturation
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'd24, 1'b0, 1'b0);
        chk_dc("sat_dcnt", 255);
        expect_entry(1'b0, 8'd20);
        expect_entry(1'b0, 8'd21);
        expect_entry(1'b0, 8'd22);
        expect_entry(1'b0, 8'd23);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
`endif

        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        chk("sb_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
